// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge port shared by the fetch unit
// (master) and the instruction memory (slave).
interface if_fetch_unit_if #(
  parameter int ADDRESS_LEN = 32
);
  logic                   req;
  logic [ADDRESS_LEN-1:0] addr;
  logic                   ack;
  logic [ADDRESS_LEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end. Owns the fetch PC, keeps one request in flight
// on the instruction-memory port, and presents {PC+4, instruction} to the IF
// stage register through a one-entry output buffer. A skid word absorbs a
// response that arrives while the buffer is frozen, and a redirect register
// remembers a branch target while an older request is still being drained.
module if_fetch_unit #(
  parameter int ADDRESS_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  if_fetch_unit_if.master        imem,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic [ADDRESS_LEN-1:0] instruction_out,
  output logic                   valid_out
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [ADDRESS_LEN-1:0] fetch_pc, fetch_pc_n;
  logic [ADDRESS_LEN-1:0] redirect_pc, redirect_pc_n;
  logic [ADDRESS_LEN-1:0] skid_q, skid_n;
  logic [ADDRESS_LEN-1:0] inst_q, inst_n;
  logic [ADDRESS_LEN-1:0] pc_q, pc_n;
  logic                   valid_q, valid_n;

  logic                   consume;
  logic                   can_accept;
  logic                   load;
  logic [ADDRESS_LEN-1:0] load_word;
  logic [ADDRESS_LEN-1:0] target;
  logic [ADDRESS_LEN-1:0] pc_plus4;

  // The IF stage takes the buffered word on every unfrozen cycle, so the
  // buffer can take a new word when empty or when it is being drained now.
  assign consume    = valid_q & ~freeze;
  assign can_accept = ~valid_q | consume;
  assign target     = {branch_addr[ADDRESS_LEN-1:2], 2'b00};
  assign pc_plus4   = fetch_pc + ADDRESS_LEN'(4);

  // Memory port: the address is always the fetch PC (in DRAIN the fetch PC
  // still names the old request, the new target waits in redirect_pc).
  assign imem.req  = ~rst & (state != S_HOLD);
  assign imem.addr = fetch_pc;

  // An empty buffer presents a NOP with a zero PC.
  assign valid_out       = valid_q;
  assign pc_out          = valid_q ? pc_q : '0;
  assign instruction_out = valid_q ? inst_q : '0;

  // Next-state logic for the fetch FSM, fetch/redirect PCs and the skid word.
  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    redirect_pc_n = redirect_pc;
    skid_n        = skid_q;
    load          = 1'b0;
    load_word     = skid_q;
    case (state)
      S_REQ: begin
        if (imem.ack) begin
          if (branch_taken) begin
            fetch_pc_n = target;
          end else if (can_accept) begin
            load       = 1'b1;
            load_word  = imem.rdata;
            fetch_pc_n = pc_plus4;
          end else begin
            skid_n  = imem.rdata;
            state_n = S_HOLD;
          end
        end else if (branch_taken) begin
          redirect_pc_n = target;
          state_n       = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          fetch_pc_n = target;
          state_n    = S_REQ;
        end else if (consume) begin
          load       = 1'b1;
          load_word  = skid_q;
          fetch_pc_n = pc_plus4;
          state_n    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (branch_taken) begin
          redirect_pc_n = target;
        end
        if (imem.ack) begin
          fetch_pc_n = branch_taken ? target : redirect_pc;
          state_n    = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
      end
    endcase
  end

  // Output buffer update: a load refills it, a consume empties it, and any
  // branch squashes it regardless of freeze.
  always_comb begin
    inst_n  = inst_q;
    pc_n    = pc_q;
    valid_n = valid_q & ~consume;
    if (load) begin
      inst_n  = load_word;
      pc_n    = pc_plus4;
      valid_n = 1'b1;
    end
    if (branch_taken) begin
      valid_n = 1'b0;
    end
  end

  // State registers; reset abandons any outstanding request and restarts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      fetch_pc    <= '0;
      redirect_pc <= '0;
      skid_q      <= '0;
      inst_q      <= '0;
      pc_q        <= '0;
      valid_q     <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      redirect_pc <= redirect_pc_n;
      skid_q      <= skid_n;
      inst_q      <= inst_n;
      pc_q        <= pc_n;
      valid_q     <= valid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by a
// randomized run checked against a program-order reference model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  int errors = 0;
  int checks = 0;

  if_fetch_unit_if #(.ADDRESS_LEN(32)) bus ();

  if_fetch_unit #(.ADDRESS_LEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem           (bus.master),
    .pc_out         (pc_out),
    .instruction_out(instruction_out),
    .valid_out      (valid_out)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Inputs are driven at the falling edge; outputs are observed there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    bus.ack      = 1'b0;
    bus.rdata    = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if (bus.req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b expected 0", bus.req); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", pc_out); end
    checks++; if (instruction_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", instruction_out); end
    rst = 1'b0;
    tick();
    checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_first_req: got req=%0b addr=%h expected 1/0", bus.req, bus.addr); end
  endtask

  task automatic test_stream();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL stream_pre_valid: got %0b expected 0", valid_out); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.addr !== 32'(4 * k)) begin errors++; $display("[TB] FAIL stream_addr%0d: got %h expected %h", k, bus.addr, 32'(4 * k)); end
      bus.ack   = 1'b1;
      bus.rdata = word_of(bus.addr);
      tick();
      checks++;
      if (valid_out !== 1'b1 || instruction_out !== word_of(32'(4 * k)) || pc_out !== 32'(4 * k + 4)) begin
        errors++;
        $display("[TB] FAIL stream_word%0d: got v=%0b i=%h pc=%h expected 1/%h/%h", k, valid_out, instruction_out, pc_out, word_of(32'(4 * k)), 32'(4 * k + 4));
      end
    end
    bus.ack = 1'b0;
    tick();
    checks++; if (valid_out !== 1'b0 || instruction_out !== 32'h0) begin errors++; $display("[TB] FAIL stream_drained: got v=%0b i=%h expected 0/0", valid_out, instruction_out); end
  endtask

  task automatic test_freeze();
    for (int k = 0; k < 2; k++) begin
      bus.ack   = 1'b1;
      bus.rdata = word_of(bus.addr);
      tick();
    end
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.ack   = bus.req;
      bus.rdata = word_of(bus.addr);
      tick();
      checks++;
      if (valid_out !== 1'b1 || instruction_out !== word_of(32'd20) || pc_out !== 32'd24) begin
        errors++;
        $display("[TB] FAIL freeze_stable%0d: got v=%0b i=%h pc=%h expected 1/%h/18", k, valid_out, instruction_out, pc_out, word_of(32'd20));
      end
      checks++; if (bus.req !== 1'b0) begin errors++; $display("[TB] FAIL freeze_hold_req%0d: got %0b expected 0", k, bus.req); end
    end
    freeze  = 1'b0;
    bus.ack = 1'b0;
    tick();
    checks++;
    if (instruction_out !== word_of(32'd24) || pc_out !== 32'd28 || bus.req !== 1'b1 || bus.addr !== 32'd28) begin
      errors++;
      $display("[TB] FAIL freeze_skid: got i=%h pc=%h req=%0b addr=%h expected %h/1c/1/1c", instruction_out, pc_out, bus.req, bus.addr, word_of(32'd24));
    end
    bus.ack   = 1'b1;
    bus.rdata = word_of(bus.addr);
    tick();
    checks++; if (instruction_out !== word_of(32'd28) || pc_out !== 32'd32) begin errors++; $display("[TB] FAIL freeze_after: got i=%h pc=%h expected %h/20", instruction_out, pc_out, word_of(32'd28)); end
    bus.ack = 1'b0;
    tick();
  endtask

  task automatic test_branch_ack();
    branch_taken = 1'b1;
    branch_addr  = 32'h103;
    bus.ack      = 1'b1;
    bus.rdata    = word_of(bus.addr);
    tick();
    branch_taken = 1'b0;
    bus.ack      = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || bus.addr !== 32'h100 || bus.req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_ack: got v=%0b addr=%h req=%0b expected 0/100/1", valid_out, bus.addr, bus.req);
    end
    bus.ack   = 1'b1;
    bus.rdata = word_of(bus.addr);
    tick();
    checks++; if (instruction_out !== word_of(32'h100) || pc_out !== 32'h104) begin errors++; $display("[TB] FAIL branch_target: got i=%h pc=%h expected %h/104", instruction_out, pc_out, word_of(32'h100)); end
    bus.ack = 1'b0;
    tick();
  endtask

  task automatic test_drain();
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    bus.ack      = 1'b1;
    bus.rdata    = word_of(bus.addr);
    tick();
    branch_taken = 1'b0;
    bus.ack      = 1'b0;
    tick();
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    tick();
    branch_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h40 || valid_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL drain_hold%0d: got req=%0b addr=%h v=%0b expected 1/40/0", k, bus.req, bus.addr, valid_out);
      end
      if (k == 0) tick();
    end
    bus.ack   = 1'b1;
    bus.rdata = word_of(32'h40);
    tick();
    checks++;
    if (valid_out !== 1'b0 || bus.addr !== 32'h200 || bus.req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_done: got v=%0b addr=%h req=%0b expected 0/200/1", valid_out, bus.addr, bus.req);
    end
    bus.rdata = word_of(bus.addr);
    tick();
    checks++; if (instruction_out !== word_of(32'h200) || pc_out !== 32'h204) begin errors++; $display("[TB] FAIL drain_target: got i=%h pc=%h expected %h/204", instruction_out, pc_out, word_of(32'h200)); end
    bus.ack = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFF;
    bus.ack      = 1'b1;
    bus.rdata    = word_of(bus.addr);
    tick();
    branch_taken = 1'b0;
    checks++; if (bus.addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected fffffffc", bus.addr); end
    bus.rdata = word_of(bus.addr);
    tick();
    checks++;
    if (valid_out !== 1'b1 || instruction_out !== word_of(32'hFFFF_FFFC) || pc_out !== 32'h0 || bus.addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_pc: got v=%0b i=%h pc=%h addr=%h expected 1/%h/0/0", valid_out, instruction_out, pc_out, bus.addr, word_of(32'hFFFF_FFFC));
    end
    bus.ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_hold();
    bus.ack   = 1'b1;
    bus.rdata = word_of(bus.addr);
    tick();
    freeze    = 1'b1;
    bus.rdata = word_of(bus.addr);
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.req !== 1'b0 || valid_out !== 1'b1) begin errors++; $display("[TB] FAIL rsthold_in_hold: got req=%0b v=%0b expected 0/1", bus.req, valid_out); end
    rst = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || pc_out !== 32'h0 || instruction_out !== 32'h0 || bus.req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rsthold_cleared: got v=%0b pc=%h i=%h req=%0b expected 0/0/0/0", valid_out, pc_out, instruction_out, bus.req);
    end
    rst    = 1'b0;
    freeze = 1'b0;
    tick();
    checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin errors++; $display("[TB] FAIL rsthold_restart: got req=%0b addr=%h expected 1/0", bus.req, bus.addr); end
    bus.ack   = 1'b1;
    bus.rdata = word_of(bus.addr);
    tick();
    checks++; if (instruction_out !== word_of(32'h0) || pc_out !== 32'h4) begin errors++; $display("[TB] FAIL rsthold_first: got i=%h pc=%h expected %h/4", instruction_out, pc_out, word_of(32'h0)); end
    bus.ack = 1'b0;
    tick();
  endtask

  // Random freeze/ack/branch traffic. The model only knows program order:
  // every presented word must be the one at the next expected PC, which
  // advances by 4 on each consumption and jumps to the target on a branch.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_branch, prev_frozen, prev_wait;
    logic        br, frz, ak;
    int          idle, consumed;
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    exp_pc      = 32'h0;
    prev_addr   = 32'h0;
    prev_branch = 1'b0;
    prev_frozen = 1'b0;
    prev_wait   = 1'b0;
    idle        = 0;
    consumed    = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_branch) begin
        checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL rand_squash@%0d: got v=%0b expected 0", cyc, valid_out); end
      end
      if (prev_frozen) begin
        checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL rand_frozen_kept@%0d: got v=%0b expected 1", cyc, valid_out); end
      end
      if (prev_wait) begin
        checks++;
        if (bus.req !== 1'b1 || bus.addr !== prev_addr) begin
          errors++;
          $display("[TB] FAIL rand_req_stable@%0d: got req=%0b addr=%h expected 1/%h", cyc, bus.req, bus.addr, prev_addr);
        end
      end
      checks++;
      if (valid_out === 1'b1) begin
        if (instruction_out !== word_of(exp_pc) || pc_out !== exp_pc + 32'd4) begin
          errors++;
          $display("[TB] FAIL rand_order@%0d: got i=%h pc=%h expected %h/%h", cyc, instruction_out, pc_out, word_of(exp_pc), exp_pc + 32'd4);
        end
        idle = 0;
      end else begin
        if (instruction_out !== 32'h0 || pc_out !== 32'h0) begin
          errors++;
          $display("[TB] FAIL rand_nop@%0d: got i=%h pc=%h expected 0/0", cyc, instruction_out, pc_out);
        end
        idle++;
      end
      checks++;
      if (idle > 60) begin
        errors++;
        $display("[TB] FAIL rand_progress@%0d: got %0d idle cycles expected at most 60", cyc, idle);
        idle = 0;
      end
      br  = ($urandom_range(99) < 6);
      frz = ($urandom_range(99) < 35);
      ak  = bus.req && ($urandom_range(99) < 55);
      branch_taken = br;
      branch_addr  = $urandom;
      freeze       = frz;
      bus.ack      = ak;
      bus.rdata    = ak ? word_of(bus.addr) : $urandom;
      prev_branch  = br;
      prev_frozen  = valid_out & frz & ~br;
      prev_wait    = bus.req & ~ak;
      prev_addr    = bus.addr;
      if (br) begin
        exp_pc = {branch_addr[31:2], 2'b00};
      end else if (valid_out && !frz) begin
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      tick();
    end
    idle_inputs();
    checks++; if (consumed < 500) begin errors++; $display("[TB] FAIL rand_throughput: got %0d consumed expected at least 500", consumed); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_freeze();
    test_branch_ack();
    test_drain();
    test_wrap();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
